// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: single-cycle multiply, 32-step restoring divide,
// with fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

    state_t          state, state_nxt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            neg_quo_q, neg_rem_q;
    logic [5:0]      cnt_q;

    logic            accept, in_mul, in_div;
    logic            sign_a, sign_b, div_signed;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] quo_nxt, rem_nxt, q_final, r_final;
    logic            div_by_zero, div_ovf, div_fast, div_finish;
    logic [XLEN-1:0] fast_res, mul_res, result_nxt;
    logic [2*XLEN-1:0] ax, bx, prod;

    assign accept = (state == S_IDLE || state == S_DONE) && start && !flush;
    assign in_mul = (state == S_MUL);
    assign in_div = (state == S_DIV);

    // Signed divide ops are DIV/REM (funct3[0] clear); magnitudes are latched at accept.
    assign div_signed = ~op[0];
    assign sign_a     = div_signed & a[XLEN-1];
    assign sign_b     = div_signed & b[XLEN-1];

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign q_final = neg_quo_q ? -quo_nxt : quo_nxt;
    assign r_final = neg_rem_q ? -rem_nxt : rem_nxt;

    assign div_by_zero = (b_q == '0);
    assign div_ovf     = ~op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    assign div_fast    = div_by_zero || div_ovf;
    assign div_finish  = div_fast || (cnt_q == CNT_LAST);
    assign fast_res    = div_by_zero ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : a_q);

    // Sign-extend to full product width; the low 2*XLEN bits of the product are exact.
    assign ax      = {{XLEN{(op_q != 2'b11) & a_q[XLEN-1]}}, a_q};
    assign bx      = {{XLEN{(op_q == 2'b01) & b_q[XLEN-1]}}, b_q};
    assign prod    = ax * bx;
    assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        result_nxt = mul_res;
        if (in_div)
            result_nxt = div_fast ? fast_res : (op_q[1] ? r_final : q_final);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: state_nxt = start ? (op[2] ? S_DIV : S_MUL) : S_IDLE;
            S_MUL:          state_nxt = S_DONE;
            S_DIV:          if (div_finish) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_comb begin
        busy = in_mul || in_div;
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result    <= '0;
        end else begin
            if (accept) begin
                op_q      <= op[1:0];
                a_q       <= a;
                b_q       <= b;
                quo_q     <= sign_a ? -a : a;
                dvs_q     <= sign_b ? -b : b;
                rem_q     <= '0;
                neg_quo_q <= sign_a ^ sign_b;
                neg_rem_q <= sign_a;
                cnt_q     <= '0;
            end else if (in_div) begin
                quo_q <= quo_nxt;
                rem_q <= rem_nxt;
                cnt_q <= cnt_q + 6'd1;
            end
            // Result only moves on the edge entering DONE; a flush leaves it untouched.
            if (!flush && (in_mul || (in_div && div_finish)))
                result <= result_nxt;
        end
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is required to work.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have start  input  1  EX-stage request to begin an M-extension op; the hazard unit's startE.
REQ-005 SHALL have op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have a  input  XLEN  rs1 operand, forwarded value.
REQ-007 SHALL have b  input  XLEN  rs2 operand, forwarded value.
REQ-008 SHALL have flush  input  1  synchronous abort, from branch-taken flush of EX.
REQ-009 SHALL have busy  output  1  op in progress; pipeline holds EX/M while high.
REQ-010 SHALL have done  output  1  single-cycle pulse: result valid.
REQ-011 SHALL have result  output  XLEN  final result, held until the next accepted op completes.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE; busy=1 exactly in MUL and DIV; done=1 exactly in DONE.
REQ-013 SHALL accept start only in IDLE or DONE; "edge 0" = the edge that samples start=1; op, a and b are registered at edge 0.
REQ-014 SHALL ignore start while busy=1; latched operands are not disturbed.
REQ-015 SHALL, for ops 000-011, enter MUL at edge 0, compute the 64-bit product at edge 1, load result, and enter DONE at edge 1 (latency 1).
REQ-016 SHALL select the product half and signedness as follows: MUL = low 32 bits; MULH = high 32 bits, signed x signed; MULHSU = high 32 bits, signed a x unsigned b; MULHU = high 32 bits, unsigned x unsigned.
REQ-017 SHALL, for ops 100-111, enter DIV at edge 0 with a 6-bit iteration counter cleared.
REQ-018 SHALL perform one restoring shift-subtract iteration per edge on edges 1..32, load result at edge 32, and enter DONE at edge 32 (latency 32).
REQ-019 SHALL divide absolute values for signed ops: quotient negated iff sign(a) XOR sign(b); remainder takes sign(a).
REQ-020 SHALL handle divide-by-zero (b=0) via a fast path: quotient 0xFFFFFFFF, remainder = a, DONE at edge 1.
REQ-021 SHALL handle signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) via a fast path: quotient 0x80000000, remainder 0, DONE at edge 1.
REQ-022 SHALL leave DONE after one cycle: to IDLE if start=0, else to MUL/DIV per the new op (back-to-back). done is still 1 during that cycle.
REQ-023 SHALL on flush=1 go to IDLE at the next edge from any state, with no done pulse and result unchanged; flush has priority over start in the same cycle.
REQ-024 SHALL keep result stable at all times except at the edge entering DONE.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, set state IDLE, busy 0, done 0, result 0, counter 0; rst has priority over flush and start.
REQ-026 SHALL abort any in-flight op when reset mid-operation, with no done pulse afterwards.

Verification
REQ-027 SHALL cover MUL a=7, b=0xFFFFFFFD -> busy 1 for 1 cycle, done at edge 1, result 0xFFFFFFEB; MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-028 SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> busy 1 for 32 cycles, done at edge 32, result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-029 SHALL cover DIVU a=5, b=0 -> done at edge 1, result 0xFFFFFFFF; REMU a=5, b=0 -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at edge 1.
REQ-030 SHALL cover flush at edge 10 of a DIVU -> busy 0 after edge 10, no done, result retains previous value; then a new MUL completes normally.
REQ-031 SHALL cover start held high in DONE with DIVU a=100, b=7 -> done 1 cycle, busy next cycle, result 14 at edge 32 of the new op.
REQ-032 SHALL cover rst at edge 5 of a DIV -> busy 0, done 0, result 0; start=1 while busy -> ignored and the original result is unchanged.
